// File: rtl/vga_pkg.sv
// vga_pkg
// Shared definitions for the VGA timing generator:
//   - default 640x480@60 timing constants (pixels / lines)
//   - comparator width for the axis counters
//   - helpers deriving axis totals and sync-pulse bounds from timing values
//   - encoding of the run-control FSM states
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } vgaState_e;

  // Total positions on one axis (active + porches + sync), e.g. 800 / 525.
  function automatic int axisTotal(input int active, input int fp,
                                   input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // First position of the sync pulse, e.g. 656 horizontally.
  function automatic int syncStart(input int active, input int fp);
    return active + fp;
  endfunction

  // Last position of the sync pulse (inclusive), e.g. 751 horizontally.
  function automatic int syncEnd(input int active, input int fp, input int sync);
    return active + fp + sync - 1;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
// One axis (horizontal or vertical) position counter, counting 0..TOTAL-1.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr_i     : hold the count at zero
//   inc_i     : advance by one this cycle (wraps TOTAL-1 -> 0)
//   count_o   : current registered count
//   next_o    : value the count takes at the next edge
//   wrap_o    : high when this cycle's increment wraps TOTAL-1 -> 0
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL = 800
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] next_o,
  output logic             wrap_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins over increment; the wrap keeps the count below TOTAL.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign wrap_o  = inc_i && !clr_i && (count_q == LAST);
  assign count_o = count_q;
  assign next_o  = count_d;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// VGA sync/position generator with a run-control FSM (IDLE / RUN / DRAIN).
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   pix_en       : pixel strobe; counters only move on cycles where it is high
//   en           : run request; dropping it lets the current frame finish
//   hsync, vsync : active-low sync pulses (held high in IDLE)
//   video_on     : high inside the active picture while running
//   pixel_x/y    : current column / line
//   frame_start  : one-cycle pulse when a frame begins at (0,0) in RUN
//   busy         : high in RUN or DRAIN
// Every output is a register loaded from the same next-state values, so all
// of them describe the same (pixel_x, pixel_y) on every cycle.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic       en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start,
  output logic       busy
);

  localparam int H_TOTAL = axisTotal(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axisTotal(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS_C  = CNT_W'(syncStart(H_ACTIVE, H_FP));
  localparam logic [CNT_W-1:0] H_SE_C  = CNT_W'(syncEnd(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [CNT_W-1:0] V_SS_C  = CNT_W'(syncStart(V_ACTIVE, V_FP));
  localparam logic [CNT_W-1:0] V_SE_C  = CNT_W'(syncEnd(V_ACTIVE, V_FP, V_SYNC));

  vgaState_e        state_q, state_d;
  logic             advance, clrCnt, vInc, hWrap, vWrap;
  logic [CNT_W-1:0] hCnt_q, hCnt_d, vCnt_q, vCnt_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;
  logic             videoOn_q, videoOn_d;
  logic             frameStart_q, frameStart_d;
  logic             busy_q, busy_d;

  // Counters sit at zero in IDLE and move only on pixel strobes otherwise.
  assign clrCnt  = (state_q == ST_IDLE);
  assign advance = pix_en && (state_q != ST_IDLE);
  assign vInc    = advance && hWrap;

  vga_axis_counter #(.TOTAL(H_TOTAL)) uHCounter (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clrCnt),
    .inc_i   (advance),
    .count_o (hCnt_q),
    .next_o  (hCnt_d),
    .wrap_o  (hWrap)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL)) uVCounter (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clrCnt),
    .inc_i   (vInc),
    .count_o (vCnt_q),
    .next_o  (vCnt_d),
    .wrap_o  (vWrap)
  );

  // Next state and next outputs. vWrap marks the strobe on which the
  // counters leave (last,last) for (0,0), i.e. the end of a frame.
  // If en comes back on that very strobe, DRAIN resumes as RUN and the new
  // frame is announced like any other.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (en && pix_en) state_d = ST_RUN;
      ST_RUN:   if (!en) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (en) begin
          state_d = ST_RUN;
        end else if (vWrap) begin
          state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase

    busy_d       = (state_d != ST_IDLE);
    videoOn_d    = busy_d && (hCnt_d < H_ACT_C) && (vCnt_d < V_ACT_C);
    hsync_d      = !(busy_d && (hCnt_d >= H_SS_C) && (hCnt_d <= H_SE_C));
    vsync_d      = !(busy_d && (vCnt_d >= V_SS_C) && (vCnt_d <= V_SE_C));
    frameStart_d = (state_d == ST_RUN) && ((state_q == ST_IDLE) || vWrap);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      videoOn_q    <= 1'b0;
      frameStart_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      videoOn_q    <= videoOn_d;
      frameStart_q <= frameStart_d;
      busy_q       <= busy_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = videoOn_q;
  assign pixel_x     = hCnt_q;
  assign pixel_y     = vCnt_q;
  assign frame_start = frameStart_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Directed bench for vga_timing_gen. dutF uses the default 640x480 timing and
// checks the horizontal boundaries of the first line. dutS uses a scaled
// timing (16 pixels x 10 lines: active 8x6, hsync on x=10..12, vsync on
// lines 7..8, 160 strobes per frame) so whole frames fit in a short run.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rstF, enF, pixF;
  logic       rstS, enS, pixS;
  logic       fHsync, fVsync, fVideoOn, fFrameStart, fBusy;
  logic [9:0] fPixelX, fPixelY;
  logic       sHsync, sVsync, sVideoOn, sFrameStart, sBusy;
  logic [9:0] sPixelX, sPixelY;

  int compared   = 0;
  int mismatched = 0;
  int kS         = 0;

  always #5 clk = ~clk;

  vga_timing_gen dutF (
    .clk         (clk),
    .rst         (rstF),
    .pix_en      (pixF),
    .en          (enF),
    .hsync       (fHsync),
    .vsync       (fVsync),
    .video_on    (fVideoOn),
    .pixel_x     (fPixelX),
    .pixel_y     (fPixelY),
    .frame_start (fFrameStart),
    .busy        (fBusy)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (1)
  ) dutS (
    .clk         (clk),
    .rst         (rstS),
    .pix_en      (pixS),
    .en          (enS),
    .hsync       (sHsync),
    .vsync       (sVsync),
    .video_on    (sVideoOn),
    .pixel_x     (sPixelX),
    .pixel_y     (sPixelY),
    .frame_start (sFrameStart),
    .busy        (sBusy)
  );

  // Packs {x, y, hsync, vsync, video_on, frame_start, busy} into one word.
  function automatic logic [31:0] vecOf(input int x, input int y, input logic hs,
                                        input logic vs, input logic vid,
                                        input logic fs, input logic bz);
    return {7'b0, 10'(x), 10'(y), hs, vs, vid, fs, bz};
  endfunction

  function automatic logic [31:0] obsF();
    return {7'b0, fPixelX, fPixelY, fHsync, fVsync, fVideoOn, fFrameStart, fBusy};
  endfunction

  function automatic logic [31:0] obsS();
    return {7'b0, sPixelX, sPixelY, sHsync, sVsync, sVideoOn, sFrameStart, sBusy};
  endfunction

  // Expected scaled-DUT outputs after k pixel strobes into a running frame.
  function automatic logic [31:0] expS(input int k, input logic fs);
    int x, y;
    x = k % 16;
    y = (k / 16) % 10;
    return vecOf(x, y, !(x >= 10 && x <= 12), !(y >= 7 && y <= 8),
                 (x < 8) && (y < 6), fs, 1'b1);
  endfunction

  logic [31:0] idleVec;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One scaled-DUT cycle with the given strobe, checked against the model.
  task automatic applyStimulus(input logic pix, input string tag);
    pixS = pix;
    tick();
    if (pix) kS++;
    checkOutput($sformatf("%s k=%0d", tag, kS), obsS(),
                expS(kS, pix && (kS % 160 == 0)));
  endtask

  // Reset the scaled DUT, then enter RUN; the first frame starts at (0,0).
  task automatic startRunS(input string tag);
    enS  = 1'b0;
    pixS = 1'b0;
    rstS = 1'b1;
    #1;
    rstS = 1'b0;
    enS  = 1'b1;
    pixS = 1'b1;
    tick();
    kS = 0;
    checkOutput(tag, obsS(), expS(0, 1'b1));
  endtask

  initial begin
    int vidCnt, hsLow, vsLow, fsCnt, lastFs, fsGap, lowCnt, lowFirst, lowLast;

    idleVec = vecOf(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    rstF = 1'b1; enF = 1'b0; pixF = 1'b0;
    rstS = 1'b1; enS = 1'b0; pixS = 1'b0;
    #3;
    checkOutput("reset values full", obsF(), idleVec);
    checkOutput("reset values scaled", obsS(), idleVec);

    // Full-size timing: first line boundaries.
    rstF = 1'b0;
    enF  = 1'b1;
    pixF = 1'b1;
    tick();
    checkOutput("F entry frame_start", obsF(), vecOf(0, 0, 1, 1, 1, 1, 1));
    tick();
    checkOutput("F x=1", obsF(), vecOf(1, 0, 1, 1, 1, 0, 1));
    repeat (638) tick();
    checkOutput("F x=639 video on", obsF(), vecOf(639, 0, 1, 1, 1, 0, 1));
    tick();
    checkOutput("F x=640 video off", obsF(), vecOf(640, 0, 1, 1, 0, 0, 1));
    lowCnt = 0; lowFirst = -1; lowLast = -1;
    repeat (160) begin
      tick();
      if (!fHsync) begin
        lowCnt++;
        if (lowFirst < 0) lowFirst = int'(fPixelX);
        lowLast = int'(fPixelX);
      end
    end
    checkOutput("F hsync low width", lowCnt, 96);
    checkOutput("F hsync first low x", lowFirst, 656);
    checkOutput("F hsync last low x", lowLast, 751);
    checkOutput("F line 1 start", obsF(), vecOf(0, 1, 1, 1, 1, 0, 1));
    rstF = 1'b1;
    enF  = 1'b0;
    #1;
    checkOutput("F async reset", obsF(), idleVec);

    // A: continuous strobe, two full frames.
    startRunS("A entry");
    vidCnt = int'(sVideoOn); hsLow = int'(!sHsync); vsLow = int'(!sVsync);
    fsCnt = 1; lastFs = 0; fsGap = 0;
    for (int i = 1; i <= 320; i++) begin
      applyStimulus(1'b1, "A run");
      if (i < 160) begin
        vidCnt += int'(sVideoOn);
        hsLow  += int'(!sHsync);
        vsLow  += int'(!sVsync);
      end
      if (sFrameStart) begin
        fsCnt++;
        fsGap  = i - lastFs;
        lastFs = i;
      end
    end
    checkOutput("A video_on per frame", vidCnt, 48);
    checkOutput("A hsync low per frame", hsLow, 30);
    checkOutput("A vsync low per frame", vsLow, 32);
    checkOutput("A frame_start count", fsCnt, 3);
    checkOutput("A frame_start gap", fsGap, 160);

    // B: strobe one cycle in four; nothing moves between strobes.
    enS = 1'b0; pixS = 1'b0; rstS = 1'b1; #1; rstS = 1'b0;
    enS = 1'b1;
    tick();
    checkOutput("B stays idle without pix_en", obsS(), idleVec);
    pixS = 1'b1;
    tick();
    kS = 0;
    checkOutput("B entry", obsS(), expS(0, 1'b1));
    lastFs = 0; fsGap = 0;
    for (int i = 1; i <= 644; i++) begin
      applyStimulus(i % 4 == 0, "B strobe");
      if (sFrameStart) begin
        fsGap  = i - lastFs;
        lastFs = i;
      end
    end
    checkOutput("B frame period in clocks", fsGap, 640);

    // C: en dropped at (4,5); drain to the wrap, then idle.
    startRunS("C entry");
    repeat (84) applyStimulus(1'b1, "C run");
    enS = 1'b0;
    applyStimulus(1'b0, "C drain stall");
    repeat (75) applyStimulus(1'b1, "C drain");
    applyStimulus(1'b0, "C drain stall at end");
    pixS = 1'b1;
    tick();
    checkOutput("C idle after wrap", obsS(), idleVec);
    fsCnt = 0;
    repeat (5) begin
      tick();
      fsCnt += int'(sFrameStart);
      checkOutput("C idle hold", obsS(), idleVec);
    end
    checkOutput("C no extra frame_start", fsCnt, 0);

    // D: en dropped at (4,5), restored at (6,7) on a non-strobe cycle.
    startRunS("D entry");
    repeat (84) applyStimulus(1'b1, "D run");
    enS = 1'b0;
    repeat (34) applyStimulus(1'b1, "D drain");
    enS = 1'b1;
    applyStimulus(1'b0, "D resume no strobe");
    repeat (42) applyStimulus(1'b1, "D run to wrap");
    checkOutput("D frame_start at wrap", obsS(), vecOf(0, 0, 1, 1, 1, 1, 1));
    repeat (3) applyStimulus(1'b1, "D next frame");

    // E: reset pulsed at (13,7) mid-frame, then a fresh frame.
    startRunS("E entry");
    repeat (125) applyStimulus(1'b1, "E run");
    checkOutput("E sync state at (13,7)", obsS(), vecOf(13, 7, 1, 0, 0, 0, 1));
    rstS = 1'b1;
    #1;
    checkOutput("E async reset same cycle", obsS(), idleVec);
    tick();
    checkOutput("E held in reset", obsS(), idleVec);
    rstS = 1'b0;
    tick();
    kS = 0;
    checkOutput("E restart frame_start", obsS(), expS(0, 1'b1));
    repeat (5) applyStimulus(1'b1, "E run after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
